prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, program-memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, instruction word width (3 nibbles).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable clocks required to accept a strobe level.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset_count  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  level, begin a load session when sampled high in IDLE or DONE.
REQ-007 SHALL have port abort  input  1  level, cancel session, no further writes.
REQ-008 SHALL have port end_addr  input  ADDR_WIDTH  last address to write in the session; sampled at session start.
REQ-009 SHALL have port nibble_in  input  4  operator switch value; sampled on accepted strobe.
REQ-010 SHALL have port nibble_strobe  input  1  raw asynchronous push-button, bouncy.
REQ-011 SHALL have port wr_addr  output  ADDR_WIDTH  program-memory write address.
REQ-012 SHALL have port wr_data  output  DATA_WIDTH  assembled instruction word.
REQ-013 SHALL have port wr_pulse  output  1  one-clock write strobe to the program-memory write port.
REQ-014 SHALL have port nib_idx  output  2  nibble expected next (0..2).
REQ-015 SHALL have port busy  output  1  high in COLLECT and WRITE.
REQ-016 SHALL have port done  output  1  high in DONE.

Function
REQ-017 SHALL pass nibble_strobe through a 2-flop synchronizer before any other use.
REQ-018 SHALL debounce: debounced level changes only after synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks; any reversion clears the count.
REQ-019 SHALL accept a nibble on the clock where the debounced level rises 0->1; total latency raw edge -> acceptance = 2 + DEBOUNCE_CYCLES clocks.
REQ-020 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-021 IDLE: start high -> COLLECT; latch end_addr; wr_addr=0, nib_idx=0, wr_data=0.
REQ-022 COLLECT: accepted nibble with nib_idx=0 -> wr_data[11:8]; 1 -> [7:4]; 2 -> [3:0]; nib_idx increments, 2 -> WRITE and nib_idx=0.
REQ-023 WRITE: wr_pulse high exactly this one clock with stable wr_addr/wr_data; next clock: if wr_addr == latched end_addr -> DONE, else wr_addr+1 -> COLLECT.
REQ-024 wr_data and wr_addr SHALL be held constant whenever wr_pulse is high and for the clock before it.
REQ-025 DONE: wr_addr holds last written address; start high -> COLLECT with wr_addr=0, new end_addr latched.
REQ-026 SHALL ignore strobe acceptances in IDLE, WRITE and DONE (not queued).
REQ-027 SHALL ignore start while busy.
REQ-028 abort high in COLLECT or WRITE -> IDLE next clock, wr_pulse forced low in that clock, partial word discarded; abort wins over simultaneous nibble acceptance or WRITE.
REQ-029 end_addr = 2**ADDR_WIDTH-1 SHALL write all addresses; wr_addr never wraps past end_addr.
REQ-030 Held button SHALL produce exactly one acceptance; a new one requires debounced release then press.

Reset
REQ-031 reset_count high SHALL immediately force state IDLE, wr_addr=0, wr_data=0, wr_pulse=0, nib_idx=0, busy=0, done=0, debounce counter=0, debounced and synchronizer levels=0, latched end_addr=0.
REQ-032 Reset asserted mid-session SHALL abandon the session with no write pulse; after release block waits for start.

Verification
REQ-033 Reset, start, end_addr=1; press nibbles 0xA,0x0,0x5 then 0x3,0xC,0xF -> wr_pulse at addr 0 data 0xA05, at addr 1 data 0x3CF, then done=1, busy=0.
REQ-034 Strobe bouncing 5 toggles each shorter than DEBOUNCE_CYCLES, then stable high 16+ clocks -> exactly one nibble accepted, nib_idx 0->1.
REQ-035 end_addr=15, 48 clean presses -> 16 write pulses, addresses 0..15 in order, no write to address 0 after 15, done=1.
REQ-036 After two nibbles (nib_idx=2) assert abort same clock as third acceptance -> no wr_pulse, state IDLE, nib_idx=0, wr_addr=0.
REQ-037 Assert reset_count asynchronously between clocks during WRITE-pending COLLECT -> all outputs reset values before next clock edge, no wr_pulse observed.
REQ-038 In DONE, raise start with end_addr=0, enter 0x1,0x2,0x3 -> single wr_pulse at addr 0 data 0x123, done=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: assembles 12-bit instruction words from three operator-entered
// nibbles (debounced push-button strobe) and writes them into consecutive
// program-memory addresses 0..end_addr.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_count,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [3:0]            nibble_in,
  input  logic                  nibble_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pulse,
  output logic [1:0]            nib_idx,
  output logic                  busy,
  output logic                  done
);

  // Debounce counter only needs to count up to DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned LAST_NIB = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            sync_q;
  logic                  deb_level;
  logic [CNT_W-1:0]      deb_cnt;
  logic                  deb_expire_c;
  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] end_lat;

  // Synchronizer and debouncer for the raw push-button.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      sync_q    <= 2'b00;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_q <= {sync_q[0], nibble_strobe};
      if (sync_q[1] != deb_level) begin
        if (deb_expire_c) begin
          deb_level <= sync_q[1];
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Acceptance fires on the same edge that the debounced level rises.
  always_comb begin
    deb_expire_c = (deb_cnt == CNT_W'(CNT_MAX));
    accept_c     = sync_q[1] & ~deb_level & deb_expire_c;
  end

  // Session FSM; WRITE spends one setup clock (wr_pulse low) then one pulse
  // clock, so address and data are stable the clock before and during the pulse.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state    <= IDLE;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_pulse <= 1'b0;
      nib_idx  <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      end_lat  <= '0;
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= COLLECT;
            end_lat <= end_addr;
            wr_addr <= '0;
            wr_data <= '0;
            nib_idx <= 2'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end

        COLLECT: begin
          if (abort) begin
            state   <= IDLE;
            wr_addr <= '0;
            wr_data <= '0;
            nib_idx <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (accept_c) begin
            case (nib_idx)
              2'd0:    wr_data[DATA_WIDTH-1 -: 4] <= nibble_in;
              2'd1:    wr_data[DATA_WIDTH-5 -: 4] <= nibble_in;
              default: wr_data[DATA_WIDTH-9 -: 4] <= nibble_in;
            endcase
            if (nib_idx >= 2'(LAST_NIB)) begin
              nib_idx <= 2'd0;
              state   <= WRITE;
            end else begin
              nib_idx <= nib_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          if (abort) begin
            state   <= IDLE;
            wr_addr <= '0;
            wr_data <= '0;
            nib_idx <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (!wr_pulse) begin
            wr_pulse <= 1'b1;
          end else if (wr_addr == end_lat) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            wr_data <= '0;
            state   <= COLLECT;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
